// File: rtl/dieu_khien_nut_nhan.sv
// dieu_khien_nut_nhan: shared-prescaler debounce for a bank of buttons, clean levels plus press pulses.
// Optional macro AUTO_REPEAT_EN adds hold-to-repeat press pulses.
module dieu_khien_nut_nhan #(
   parameter int N_BTN       = 4,
   parameter int TICK_DIV    = 500000,
   parameter int STABLE_CNT  = 4,
   parameter int BTN_ACT_LOW = 1,
   parameter int REP_DELAY   = 50,
   parameter int REP_RATE    = 10
) (
   input  logic             ckht,
   input  logic             rst_n,
   input  logic             en,
   input  logic [N_BTN-1:0] btn_in,
   output logic [N_BTN-1:0] btn_lvl,
   output logic [N_BTN-1:0] btn_press,
   output logic             tick_o
);
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [N_BTN-1:0] REL = BTN_ACT_LOW != 0 ? {N_BTN{1'b1}} : {N_BTN{1'b0}};
   typedef enum logic [1:0] {NHA, CHO_NHAN, NHAN, CHO_NHA} state_t;
   logic [PW-1:0]    pre;
   logic [N_BTN-1:0] s1, s2, p, press_n;
   state_t           st [N_BTN];
   state_t           st_n [N_BTN];
   logic [3:0]       cnt [N_BTN];
   logic [3:0]       cnt_n [N_BTN];
`ifdef AUTO_REPEAT_EN
   logic [6:0]       hold [N_BTN];
   logic [6:0]       hold_n [N_BTN];
   logic [6:0]       h1;
`else
   logic             unused_rep;
   assign unused_rep = (REP_DELAY + REP_RATE) > 0;
`endif
   assign p = BTN_ACT_LOW != 0 ? ~s2 : s2;
   assign tick_o = en && pre == PW'(TICK_DIV - 1);
   always_ff @(posedge ckht) begin
      if (!rst_n) begin
         pre <= '0;
         s1 <= REL;
         s2 <= REL;
         btn_press <= '0;
         for (int i = 0; i < N_BTN; i++) begin
            st[i] <= NHA;
            cnt[i] <= '0;
`ifdef AUTO_REPEAT_EN
            hold[i] <= '0;
`endif
         end
      end else begin
         s1 <= btn_in;
         s2 <= s1;
         btn_press <= press_n;
         if (en) pre <= tick_o ? '0 : pre + 1'b1;
         for (int i = 0; i < N_BTN; i++) begin
            st[i] <= st_n[i];
            cnt[i] <= cnt_n[i];
`ifdef AUTO_REPEAT_EN
            hold[i] <= hold_n[i];
`endif
         end
      end
   end
   // The FSMs only move on a tick, so en=0 freezes them along with the prescaler.
   always_comb begin
      press_n = '0;
      btn_lvl = '0;
`ifdef AUTO_REPEAT_EN
      h1 = '0;
`endif
      for (int i = 0; i < N_BTN; i++) begin
         st_n[i] = st[i];
         cnt_n[i] = cnt[i];
         btn_lvl[i] = st[i] == NHAN || st[i] == CHO_NHA;
`ifdef AUTO_REPEAT_EN
         hold_n[i] = hold[i];
`endif
         if (tick_o) begin
            case (st[i])
               NHA: if (p[i]) begin
                  st_n[i] = STABLE_CNT == 1 ? NHAN : CHO_NHAN;
                  cnt_n[i] = STABLE_CNT == 1 ? 4'd0 : 4'd1;
                  press_n[i] = STABLE_CNT == 1;
`ifdef AUTO_REPEAT_EN
                  hold_n[i] = '0;
`endif
               end
               CHO_NHAN: if (!p[i]) begin
                  st_n[i] = NHA;
                  cnt_n[i] = '0;
               end else if (cnt[i] + 4'd1 == 4'(STABLE_CNT)) begin
                  st_n[i] = NHAN;
                  cnt_n[i] = '0;
                  press_n[i] = 1'b1;
`ifdef AUTO_REPEAT_EN
                  hold_n[i] = '0;
`endif
               end else cnt_n[i] = cnt[i] + 4'd1;
               NHAN: if (!p[i]) begin
                  st_n[i] = STABLE_CNT == 1 ? NHA : CHO_NHA;
                  cnt_n[i] = STABLE_CNT == 1 ? 4'd0 : 4'd1;
               end else begin
`ifdef AUTO_REPEAT_EN
                  // Folding back to REP_DELAY after each period keeps the 7-bit counter from overflowing.
                  h1 = hold[i] + 7'd1;
                  press_n[i] = h1 == 7'(REP_DELAY) || h1 == 7'(REP_DELAY + REP_RATE);
                  hold_n[i] = h1 == 7'(REP_DELAY + REP_RATE) ? 7'(REP_DELAY) : h1;
`endif
               end
               CHO_NHA: if (p[i]) begin
                  st_n[i] = NHAN;
                  cnt_n[i] = '0;
               end else if (cnt[i] + 4'd1 == 4'(STABLE_CNT)) begin
                  st_n[i] = NHA;
                  cnt_n[i] = '0;
               end else cnt_n[i] = cnt[i] + 4'd1;
            endcase
         end
      end
   end
endmodule
